uart_rx: RTL
============

# uart_rx

UART receiver that turns an asynchronous serial line into an AXI4-Stream master output. It is the receive-side counterpart to the team's `uart_tx` and shares its frame format: 1 start bit (low), DATA_WIDTH data bits LSB first, 1 stop bit (high), no parity. It sits between the board-level RX pin and downstream stream logic such as FIFOs and command parsers.

## Interface
- CLK_FREQ, 50_000_000, clk frequency in Hz
- BAUD_RATE, 9600, line bit rate
- DATA_WIDTH, 8, data bits per frame
- Derived: BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer division, must be ≥ 4); HALF = BIT_PERIOD / 2
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rx_wire  input  1  serial line, asynchronous to clk, idles high
- m_axis_tdata  output  DATA_WIDTH  received byte
- m_axis_tvalid  output  1  tdata holds an unconsumed byte
- m_axis_tready  input  1  downstream accepts
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: byte dropped because output still full

## Operation
- rx_wire passes through a 2-flop synchronizer; both flops reset to 1. rx_s is the synchronizer output, and rx_d is rx_s delayed by one flop (also resets to 1).
- Counters:
  - baud_cnt is $clog2(BIT_PERIOD) bits wide and wraps at BIT_PERIOD-1.
  - bit_cnt is $clog2(DATA_WIDTH)+1 bits wide.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: baud_cnt=0, bit_cnt=0. On rx_d=1 and rx_s=0 (falling edge), go to START. A line held low, such as a break, does not retrigger.
  - START: count to HALF-1, then sample rx_s. If low, clear baud_cnt and go to DATA. If high, it was a glitch: go to IDLE with no output and no error.
  - DATA: sample rx_s each time baud_cnt reaches BIT_PERIOD-1. Shift it into the shift register from the MSB side, so the first bit ends up at bit 0. Increment bit_cnt. After DATA_WIDTH samples, go to STOP.
  - STOP: sample at baud_cnt = BIT_PERIOD-1. If high, the frame is valid; go to IDLE. If low, pulse frame_err for 1 cycle, discard the shift register, and go to IDLE.
- Output register behaviour on a valid frame:
  - If tvalid=0, load the byte into tdata and set tvalid=1.
  - If tvalid=1 and tready=1 in that same cycle, the old byte is consumed and the new byte is loaded; tvalid stays 1 and there is no error.
  - If tvalid=1 and tready=0, drop the new byte, keep the old tdata, and pulse overrun_err for 1 cycle.
- AXI handshake:
  - Transfer occurs on tvalid & tready.
  - tvalid clears the next cycle unless a new byte loads in that same cycle.
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.
- The receiver never stalls the line. Sampling continues while the output is full.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, frame_err=0, overrun_err=0, FSM=IDLE, counters=0.
- Reset mid-frame aborts immediately with no output. After reset is released, the receiver waits for a fresh falling edge.
- Input to detection: an edge on rx_wire is detected 3 clk edges later (2 synchronizer flops plus the rx_d compare).
- Sample points: let E be the detection cycle. Samples occur at E+HALF for the start bit, then E+HALF+k·BIT_PERIOD for k=1..DATA_WIDTH (data) and k=DATA_WIDTH+1 (stop).
- Output timing: tvalid, frame_err and overrun_err assert in the cycle after the stop sample. Detection to tvalid is HALF + (DATA_WIDTH+1)·BIT_PERIOD + 1 cycles.
- Back-to-back frames: IDLE is re-entered right after the stop sample, so a start edge arriving half a bit into the stop bit is caught.
- Tolerance: ±HALF cycles of accumulated drift per frame.

## Test plan
- Use CLK_FREQ=160, BAUD_RATE=10 (BIT_PERIOD=16), DATA_WIDTH=8, and drive serial frames from a bench model.
- **Single byte:** send 0xA5 with tready=1 → one transfer with tdata=0xA5. tvalid rises exactly 8+9·16+1=153 cycles after detection. No errors.
- **Backpressure and overrun:** with tready=0, send 0x3C then 0xC3 → tdata stays 0x3C, overrun_err pulses once after the second stop bit. Raise tready → 0x3C is transferred, then tvalid=0.
- **Simultaneous consume and load:** hold 0x11 in the output, send 0x22, and pulse tready exactly in the completion cycle → tvalid stays 1, tdata=0x22, no overrun_err.
- **Framing error and glitch:**
  - Send 0x55 with the stop bit forced low → frame_err pulses once, and tvalid stays 0.
  - A 4-cycle low glitch on idle rx_wire → no output and no error.
- **Back-to-back and reset:**
  - Send 0x00 and 0xFF with no idle gap, tready=1 → two transfers, in order.
  - Assert rst during data bit 4 → all outputs are 0 immediately. A following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style serial frames in, AXI4-Stream master out.
// Mid-bit sampling from a detected start edge; single-entry output register with overrun flag.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_wire,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int unsigned BitPeriod = CLK_FREQ / BAUD_RATE;
    localparam int unsigned Half      = BitPeriod / 2;
    localparam int unsigned CntW      = $clog2(BitPeriod);
    localparam int unsigned BitW      = $clog2(DATA_WIDTH) + 1;

    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(BitPeriod - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_d_q;
    logic [CntW-1:0]       baud_cnt_q, baud_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_ok;

    // Synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_wire;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_ok    = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                // Edge, not level: a line held low (break) cannot retrigger
                if (rx_d_q && !rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_cnt_q == HalfLast) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s_q ? StIdle : StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == DataLast) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    if (rx_s_q) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        // A consume in the completion cycle frees the slot for the new byte
        if (frame_ok) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = frame_err_q;
    assign overrun_err   = overrun_q;

endmodule
